// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store unit.
//   - funct3 access-size codes (RISC-V encoding)
//   - LSU FSM state encoding
//   - f3_legal(): is a funct3 value a legal load/store size?
package lsu_mem_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Unsigned variants only exist for loads.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Bundle of the MEM-stage request/response and data-memory bus signals.
//   slave  : the LSU view (requests and memory response in; stall, response,
//            errors and memory request out)
//   master : the environment view (pipeline plus data memory)
interface lsu_mem_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic              req_valid;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              stall;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              misalign_err;
  logic              bus_err;
  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    output stall, resp_valid, resp_rdata, misalign_err, bus_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    input  stall, resp_valid, resp_rdata, misalign_err, bus_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_ctrl_align.sv
// Combinational lane logic for the LSU.
//   we, f3, addr_lo : access type, size and byte offset within the word
//   wdata           : right-justified store data
//   rdata           : raw memory read word
//   be              : byte-lane enables (lanes above the low word stay 0)
//   wdata_rep       : store data replicated across all lanes
//   bad             : illegal funct3 or misaligned address
//   rdata_ext       : selected load lane, sign/zero-extended to XLEN
module lsu_mem_ctrl_align
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              we,
  input  logic [2:0]        f3,
  input  logic [1:0]        addr_lo,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   wdata_rep,
  output logic              bad,
  output logic [XLEN-1:0]   rdata_ext
);

  logic [3:0]  be4;
  logic        mis;
  logic        sx;
  logic [15:0] lane;

  always_comb begin
    be4       = '0;
    wdata_rep = '0;
    mis       = 1'b0;
    case (f3[1:0])
      2'b00: begin
        be4       = 4'b0001 << addr_lo;
        wdata_rep = {(XLEN/8){wdata[7:0]}};
      end
      2'b01: begin
        be4       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {(XLEN/16){wdata[15:0]}};
        mis       = addr_lo[0];
      end
      2'b10: begin
        be4       = 4'b1111;
        wdata_rep = {(XLEN/32){wdata[31:0]}};
        mis       = |addr_lo;
      end
      default: ;
    endcase
    bad   = !f3_legal(we, f3) || mis;
    be    = '0;
    be[3:0] = be4;
  end

  always_comb begin
    lane      = 16'(rdata[31:0] >> {addr_lo, 3'b000});
    sx        = !f3[2];
    rdata_ext = '0;
    case (f3[1:0])
      2'b00: begin
        rdata_ext       = {XLEN{sx & lane[7]}};
        rdata_ext[7:0]  = lane[7:0];
      end
      2'b01: begin
        rdata_ext       = {XLEN{sx & lane[15]}};
        rdata_ext[15:0] = lane;
      end
      2'b10: begin
        rdata_ext       = {XLEN{rdata[31]}};
        rdata_ext[31:0] = rdata[31:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the MEM stage and a variable-latency data memory.
//   clk     : clock, rising edge
//   rst     : asynchronous, active-low reset
//   bus     : lsu_mem_ctrl_if.slave - MEM-stage request, stall, response and
//             error pulses, and the data-memory request/ack bus
// FSM IDLE -> WAIT -> DONE -> IDLE. A legal request drives mem_req/stall
// combinationally from IDLE; ack in the k-th request cycle gives resp_valid in
// cycle k+1. With TIMEOUT != 0 the access is abandoned after TIMEOUT request
// cycles without ack and completes with bus_err.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  lsu_mem_ctrl_if.slave bus
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [1:0]        state_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;
  logic              berr_q;
  logic [CW-1:0]     cnt_q;

  logic              is_idle;
  logic              sel_we;
  logic [2:0]        sel_f3;
  logic [XLEN-1:0]   sel_addr;
  logic [XLEN-1:0]   sel_wdata;
  logic [XLEN/8-1:0] be;
  logic [XLEN-1:0]   wdata_rep;
  logic              bad;
  logic [XLEN-1:0]   rdata_ext;
  logic              start;
  logic              illegal;
  logic              busy;
  logic [CW:0]       cur;
  logic              tmo;

  // Hold registers keep the raw request fields; lanes and load extension are
  // recomputed from them by the single align instance, so the bus stays
  // identical to the first request cycle.
  assign is_idle   = (state_q == ST_IDLE);
  assign sel_we    = is_idle ? bus.req_we     : we_q;
  assign sel_f3    = is_idle ? bus.req_funct3 : f3_q;
  assign sel_addr  = is_idle ? bus.req_addr   : addr_q;
  assign sel_wdata = is_idle ? bus.req_wdata  : wdata_q;

  lsu_mem_ctrl_align #(.XLEN(XLEN)) u_align (
    .we        (sel_we),
    .f3        (sel_f3),
    .addr_lo   (sel_addr[1:0]),
    .wdata     (sel_wdata),
    .rdata     (bus.mem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .bad       (bad),
    .rdata_ext (rdata_ext)
  );

  // rst gating keeps every output low while reset is asserted.
  assign start   = rst && is_idle && bus.req_valid && !bad;
  assign illegal = rst && is_idle && bus.req_valid && bad;
  assign busy    = start || (state_q == ST_WAIT);

  // cur = number of request cycles including the present one.
  assign cur = is_idle ? (CW+1)'(1) : ({1'b0, cnt_q} + 1'b1);
  assign tmo = (TIMEOUT != 0) && (32'(cur) >= TIMEOUT);

  assign bus.stall        = busy;
  assign bus.mem_req      = busy;
  assign bus.mem_we       = busy && sel_we;
  assign bus.mem_addr     = busy ? {sel_addr[XLEN-1:2], 2'b00} : '0;
  assign bus.mem_be       = busy ? be : '0;
  assign bus.mem_wdata    = busy ? wdata_rep : '0;
  assign bus.resp_valid   = (state_q == ST_DONE) || illegal;
  assign bus.resp_rdata   = (state_q == ST_DONE) ? rdata_q : '0;
  assign bus.misalign_err = illegal;
  assign bus.bus_err      = (state_q == ST_DONE) && berr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      berr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (start) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (busy) begin
        if (bus.mem_ack) begin
          rdata_q <= sel_we ? '0 : rdata_ext;
          berr_q  <= 1'b0;
          state_q <= ST_DONE;
        end else if (tmo) begin
          rdata_q <= '0;
          berr_q  <= 1'b1;
          state_q <= ST_DONE;
        end else begin
          cnt_q   <= cur[CW-1:0];
          state_q <= ST_WAIT;
        end
      end else if (state_q == ST_DONE) begin
        rdata_q <= '0;
        berr_q  <= 1'b0;
        cnt_q   <= '0;
        state_q <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;
  import lsu_mem_ctrl_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TMO  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  lsu_mem_ctrl_if #(.XLEN(XLEN)) bus ();

  lsu_mem_ctrl #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        merr;
    logic        berr;
    int          stall_cyc;
  } exp_t;

  exp_t sb[$];

  task automatic drive_idle();
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  // One access: request driven at cycle start, memory acks in request cycle
  // ack_k (0 = never). Expected response is queued at drive time and popped
  // when resp_valid is seen.
  task automatic access(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] mrdata, input int ack_k,
                        input logic [31:0] exp_rdata, input logic exp_merr,
                        input logic exp_berr, input int exp_stall,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    exp_t e;
    exp_t got;
    int   stalls;
    bit   seen;
    logic [31:0] exp_addr;
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    e.rdata = exp_rdata; e.merr = exp_merr; e.berr = exp_berr; e.stall_cyc = exp_stall;
    sb.push_back(e);
    exp_addr = {addr[31:2], 2'b00};
    stalls = 0;
    seen   = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      bus.mem_ack   = (k == ack_k);
      bus.mem_rdata = (k == ack_k) ? mrdata : $urandom;
      @(negedge clk);
      if (bus.resp_valid) begin
        seen = 1'b1;
        got  = sb.pop_front();
        checks++;
        if (bus.resp_rdata !== got.rdata) begin
          errors++;
          $display("FAIL %s rdata: got %h want %h", name, bus.resp_rdata, got.rdata);
        end
        checks++;
        if (bus.misalign_err !== got.merr) begin
          errors++;
          $display("FAIL %s misalign_err: got %b want %b", name, bus.misalign_err, got.merr);
        end
        checks++;
        if (bus.bus_err !== got.berr) begin
          errors++;
          $display("FAIL %s bus_err: got %b want %b", name, bus.bus_err, got.berr);
        end
        checks++;
        if (stalls != got.stall_cyc) begin
          errors++;
          $display("FAIL %s stall cycles: got %0d want %0d", name, stalls, got.stall_cyc);
        end
        checks++;
        if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0) begin
          errors++;
          $display("FAIL %s req/stall at resp: got %b/%b want 0/0", name, bus.mem_req, bus.stall);
        end
      end else begin
        if (bus.stall === 1'b1) stalls++;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== exp_addr || bus.mem_be !== exp_be ||
            bus.mem_we !== we) begin
          errors++;
          $display("FAIL %s bus cycle %0d: got req=%b addr=%h be=%b we=%b want 1 %h %b %b",
                   name, k, bus.mem_req, bus.mem_addr, bus.mem_be, bus.mem_we,
                   exp_addr, exp_be, we);
        end
        if (we) begin
          checks++;
          if (bus.mem_wdata !== exp_wdata) begin
            errors++;
            $display("FAIL %s mem_wdata: got %h want %h", name, bus.mem_wdata, exp_wdata);
          end
        end
        @(posedge clk); #1;
      end
    end
    bus.mem_ack = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s no resp_valid within 20 cycles", name);
      if (sb.size() != 0) void'(sb.pop_front());
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0 || bus.mem_req !== 1'b0 || bus.resp_valid !== 1'b0 ||
        bus.misalign_err !== 1'b0 || bus.bus_err !== 1'b0) begin
      errors++;
      $display("FAIL reset ctrl: got stall=%b req=%b rv=%b me=%b be=%b want all 0",
               bus.stall, bus.mem_req, bus.resp_valid, bus.misalign_err, bus.bus_err);
    end
    checks++;
    if (bus.mem_addr !== '0 || bus.mem_be !== '0 || bus.mem_wdata !== '0 ||
        bus.resp_rdata !== '0 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset data: got addr=%h be=%b wd=%h rd=%h we=%b want 0",
               bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.resp_rdata, bus.mem_we);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_lw_latency();
    access("lw_k3", 1'b0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 3,
           32'hDEADBEEF, 1'b0, 1'b0, 3, 4'b1111, 32'h0);
    idle_cycle();
  endtask

  task automatic test_load_extend();
    access("lb_103",  1'b0, F3_B,  32'h103, 32'h0, 32'h80FFFF7F, 1, 32'hFFFFFF80, 1'b0, 1'b0, 1, 4'b1000, 32'h0);
    access("lbu_103", 1'b0, F3_BU, 32'h103, 32'h0, 32'h80FFFF7F, 1, 32'h00000080, 1'b0, 1'b0, 1, 4'b1000, 32'h0);
    access("lh_102",  1'b0, F3_H,  32'h102, 32'h0, 32'h80FFFF7F, 2, 32'hFFFF80FF, 1'b0, 1'b0, 2, 4'b1100, 32'h0);
    access("lhu_100", 1'b0, F3_HU, 32'h100, 32'h0, 32'h80FFFF7F, 1, 32'h0000FF7F, 1'b0, 1'b0, 1, 4'b0011, 32'h0);
    access("lb_100",  1'b0, F3_B,  32'h100, 32'h0, 32'h80FFFF7F, 1, 32'h0000007F, 1'b0, 1'b0, 1, 4'b0001, 32'h0);
    idle_cycle();
  endtask

  task automatic test_store_lanes();
    access("sh_102", 1'b1, F3_H, 32'h102, 32'h00001234, 32'hFFFFFFFF, 2, 32'h0, 1'b0, 1'b0, 2, 4'b1100, 32'h12341234);
    access("sb_101", 1'b1, F3_B, 32'h101, 32'h000000AB, 32'hFFFFFFFF, 1, 32'h0, 1'b0, 1'b0, 1, 4'b0010, 32'hABABABAB);
    access("sw_104", 1'b1, F3_W, 32'h104, 32'h13579BDF, 32'hFFFFFFFF, 3, 32'h0, 1'b0, 1'b0, 3, 4'b1111, 32'h13579BDF);
    idle_cycle();
  endtask

  task automatic test_illegal();
    access("lw_mis",  1'b0, F3_W,   32'h102, 32'h0, 32'h12345678, 1, 32'h0, 1'b1, 1'b0, 0, 4'b0000, 32'h0);
    access("f3_011",  1'b0, 3'b011, 32'h100, 32'h0, 32'h12345678, 1, 32'h0, 1'b1, 1'b0, 0, 4'b0000, 32'h0);
    access("sbu_st",  1'b1, F3_BU,  32'h100, 32'h0, 32'h12345678, 1, 32'h0, 1'b1, 1'b0, 0, 4'b0000, 32'h0);
    access("sh_mis",  1'b1, F3_H,   32'h101, 32'h0, 32'h12345678, 1, 32'h0, 1'b1, 1'b0, 0, 4'b0000, 32'h0);
    idle_cycle();
  endtask

  task automatic test_timeout();
    access("tmo",        1'b0, F3_W, 32'h200, 32'h0, 32'h0, 0, 32'h0, 1'b0, 1'b1, TMO, 4'b1111, 32'h0);
    idle_cycle();
    access("ack_at_tmo", 1'b0, F3_W, 32'h204, 32'h0, 32'hA5A55A5A, TMO, 32'hA5A55A5A, 1'b0, 1'b0, TMO, 4'b1111, 32'h0);
    idle_cycle();
  endtask

  task automatic test_ack_in_idle();
    @(posedge clk); #1;
    drive_idle();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFFFFFF;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.stall !== 1'b0 || bus.mem_req !== 1'b0) begin
        errors++;
        $display("FAIL idle_ack: got rv=%b stall=%b req=%b want 0/0/0",
                 bus.resp_valid, bus.stall, bus.mem_req);
      end
    end
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h300;
    bus.mem_ack    = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait pre: mem_req got %b want 1", bus.mem_req);
    end
    #2;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0 || bus.resp_valid !== 1'b0 || bus.bus_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait async: got req=%b stall=%b rv=%b be=%b want 0",
               bus.mem_req, bus.stall, bus.resp_valid, bus.bus_err);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.bus_err !== 1'b0 || bus.mem_req !== 1'b0) begin
        errors++;
        $display("FAIL rst_wait held: got rv=%b be=%b req=%b want 0",
                 bus.resp_valid, bus.bus_err, bus.mem_req);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    access("sw_after_rst", 1'b1, F3_W, 32'h10C, 32'hCAFEF00D, 32'h0, 2,
           32'h0, 1'b0, 1'b0, 2, 4'b1111, 32'hCAFEF00D);
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    access("b2b_lb",  1'b0, F3_B,  32'h101, 32'h0,   32'h0000F700, 1, 32'hFFFFFFF7, 1'b0, 1'b0, 1, 4'b0010, 32'h0);
    access("b2b_sb",  1'b1, F3_B,  32'h102, 32'h1FF, 32'h0,        2, 32'h0,        1'b0, 1'b0, 2, 4'b0100, 32'hFFFFFFFF);
    access("b2b_lhu", 1'b0, F3_HU, 32'h102, 32'h0,   32'hABCD1234, 1, 32'h0000ABCD, 1'b0, 1'b0, 1, 4'b1100, 32'h0);
    access("b2b_mis", 1'b0, F3_H,  32'h103, 32'h0,   32'h0,        1, 32'h0,        1'b1, 1'b0, 0, 4'b0000, 32'h0);
    access("b2b_lw",  1'b0, F3_W,  32'h108, 32'h0,   32'h01020304, 1, 32'h01020304, 1'b0, 1'b0, 1, 4'b1111, 32'h0);
    idle_cycle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_lw_latency();
    test_load_extend();
    test_store_lanes();
    test_illegal();
    test_timeout();
    test_ack_in_idle();
    test_reset_mid_wait();
    test_back_to_back();
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: got %0d entries want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
